// File: rtl/pe_traffic_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pe_traffic_gen                                               |
// | Description : Processing-element traffic generator. Polls a NIC register   |
// |               map, injects stamped packets and drains received packets.    |
// |               Optional rx XOR accumulator: PE_TRAFFIC_GEN_RXXOR_EN.        |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module pe_traffic_gen #(
  parameter int unsigned PACKET_WIDTH = 64,
  parameter logic [7:0]  SRC_ID       = 8'd0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [15:0]             num_pkts,
  input  logic [15:0]             exp_rx,
  input  logic [15:0]             dest_hdr,
  input  logic [7:0]              gap,
  output logic [1:0]              addr,
  output logic [PACKET_WIDTH-1:0] d_in,
  input  logic [PACKET_WIDTH-1:0] d_out,
  output logic                    nicEn,
  output logic                    nicEnWR,
  output logic                    busy,
  output logic                    done,
  output logic [15:0]             tx_cnt,
  output logic [15:0]             rx_cnt,
  output logic [PACKET_WIDTH-1:0] last_rx,
  output logic [PACKET_WIDTH-1:0] rx_xor
);

  localparam logic [1:0] ADDR_IN_BUF   = 2'b00;
  localparam logic [1:0] ADDR_IN_STAT  = 2'b01;
  localparam logic [1:0] ADDR_OUT_BUF  = 2'b10;
  localparam logic [1:0] ADDR_OUT_STAT = 2'b11;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    POLL_OUT = 4'd1,
    CHK_OUT  = 4'd2,
    WR       = 4'd3,
    POLL_IN  = 4'd4,
    CHK_IN   = 4'd5,
    RD_IN    = 4'd6,
    CAP_IN   = 4'd7,
    DONE     = 4'd8
  } state_t;

  state_t                  state_q, state_d;
  logic [15:0]             tx_cnt_q, tx_cnt_d;
  logic [15:0]             rx_cnt_q, rx_cnt_d;
  logic [7:0]              gap_q, gap_d;
  logic [PACKET_WIDTH-1:0] last_rx_q, last_rx_d;
  logic [63:0]             pkt_w;
  logic                    run_clr_w;
  logic                    cap_w;

  assign pkt_w     = {dest_hdr, SRC_ID, 8'h00, 16'h0000, tx_cnt_q};
  assign run_clr_w = (state_q == IDLE) && start;
  assign cap_w     = (state_q == CAP_IN);

  always_comb begin
    state_d   = state_q;
    tx_cnt_d  = tx_cnt_q;
    rx_cnt_d  = rx_cnt_q;
    last_rx_d = last_rx_q;
    gap_d     = (gap_q != 8'd0) ? gap_q - 8'd1 : gap_q;
    nicEn     = 1'b0;
    nicEnWR   = 1'b0;
    addr      = ADDR_IN_BUF;
    d_in      = '0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        busy  = 1'b0;
        gap_d = gap_q;
        if (start) begin
          tx_cnt_d  = 16'd0;
          rx_cnt_d  = 16'd0;
          gap_d     = 8'd0;
          last_rx_d = '0;
          state_d   = POLL_OUT;
        end
      end
      POLL_OUT: begin
        nicEn   = 1'b1;
        addr    = ADDR_OUT_STAT;
        state_d = CHK_OUT;
      end
      CHK_OUT: begin
        // d_out carries the output-status word requested in POLL_OUT
        if (!d_out[0] && (tx_cnt_q < num_pkts) && (gap_q == 8'd0)) state_d = WR;
        else                                                        state_d = POLL_IN;
      end
      WR: begin
        nicEn    = 1'b1;
        nicEnWR  = 1'b1;
        addr     = ADDR_OUT_BUF;
        d_in     = PACKET_WIDTH'(pkt_w);
        tx_cnt_d = tx_cnt_q + 16'd1;
        gap_d    = gap;
        state_d  = POLL_IN;
      end
      POLL_IN: begin
        nicEn   = 1'b1;
        addr    = ADDR_IN_STAT;
        state_d = CHK_IN;
      end
      CHK_IN: begin
        if (d_out[0])                                         state_d = RD_IN;
        else if ((tx_cnt_q == num_pkts) && (rx_cnt_q == exp_rx)) state_d = DONE;
        else                                                  state_d = POLL_OUT;
      end
      RD_IN: begin
        nicEn   = 1'b1;
        addr    = ADDR_IN_BUF;
        state_d = CAP_IN;
      end
      CAP_IN: begin
        last_rx_d = d_out;
        rx_cnt_d  = rx_cnt_q + 16'd1;
        state_d   = POLL_OUT;
      end
      DONE: begin
        busy = 1'b0;
        done = 1'b1;
        if (!start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      tx_cnt_q  <= 16'd0;
      rx_cnt_q  <= 16'd0;
      gap_q     <= 8'd0;
      last_rx_q <= '0;
    end else begin
      state_q   <= state_d;
      tx_cnt_q  <= tx_cnt_d;
      rx_cnt_q  <= rx_cnt_d;
      gap_q     <= gap_d;
      last_rx_q <= last_rx_d;
    end
  end

`ifdef PE_TRAFFIC_GEN_RXXOR_EN
  logic [PACKET_WIDTH-1:0] rx_xor_q, rx_xor_d;

  always_comb begin
    rx_xor_d = rx_xor_q;
    if (run_clr_w)  rx_xor_d = '0;
    else if (cap_w) rx_xor_d = rx_xor_q ^ d_out;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rx_xor_q <= '0;
    else        rx_xor_q <= rx_xor_d;
  end

  assign rx_xor = rx_xor_q;
`else
  logic unused_w;
  assign unused_w = run_clr_w ^ cap_w;
  assign rx_xor   = '0;
`endif

  assign tx_cnt  = tx_cnt_q;
  assign rx_cnt  = rx_cnt_q;
  assign last_rx = last_rx_q;

endmodule
`default_nettype wire

// File: tb/tb_pe_traffic_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_pe_traffic_gen                                            |
// | Description : Directed self-checking bench with a registered NIC model.    |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_pe_traffic_gen;

  localparam int unsigned PW  = 64;
  localparam logic [7:0]  SID = 8'h3C;
`ifdef PE_TRAFFIC_GEN_RXXOR_EN
  localparam logic [63:0] XOR_EXP = 64'hFF;
`else
  localparam logic [63:0] XOR_EXP = 64'h0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [15:0]   num_pkts = '0, exp_rx = '0, dest_hdr = '0;
  logic [7:0]    gap = '0;
  logic [1:0]    addr;
  logic [PW-1:0] d_in, d_out = '0;
  logic          nicEn, nicEnWR, busy, done;
  logic [15:0]   tx_cnt, rx_cnt;
  logic [PW-1:0] last_rx, rx_xor;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int clr_time;
  logic out_full = 1'b0;
  logic [63:0] in_q[$];
  int          wr_time[$];
  logic [63:0] wr_data[$];

  pe_traffic_gen #(.PACKET_WIDTH(PW), .SRC_ID(SID)) dut (
    .clk(clk), .reset(reset), .start(start), .num_pkts(num_pkts),
    .exp_rx(exp_rx), .dest_hdr(dest_hdr), .gap(gap), .addr(addr),
    .d_in(d_in), .d_out(d_out), .nicEn(nicEn), .nicEnWR(nicEnWR),
    .busy(busy), .done(done), .tx_cnt(tx_cnt), .rx_cnt(rx_cnt),
    .last_rx(last_rx), .rx_xor(rx_xor)
  );

  always #5 clk = ~clk;

  // NIC: read data registered, valid the cycle after the request
  always @(posedge clk) begin
    logic [63:0] pkt;
    cyc++;
    if (nicEn && nicEnWR) begin
      wr_time.push_back(cyc);
      wr_data.push_back(d_in);
    end else if (nicEn) begin
      case (addr)
        2'b00: begin
          pkt = (in_q.size() > 0) ? in_q.pop_front() : 64'h0;
          d_out <= pkt;
        end
        2'b01:   d_out <= {63'h0, in_q.size() > 0};
        2'b11:   d_out <= {63'h0, out_full};
        default: d_out <= '0;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, input string tag);
    int n = 0;
    while (done !== 1'b1 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done"}, {63'h0, done}, 64'h1);
  endtask

  task automatic clear_log();
    wr_time.delete();
    wr_data.delete();
  endtask

  function automatic int wt(input int i);
    return (wr_time.size() > i) ? wr_time[i] : -1000;
  endfunction

  function automatic logic [63:0] wd(input int i);
    return (wr_data.size() > i) ? wr_data[i] : 64'hDEAD;
  endfunction

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_busy",    {63'h0, busy},    64'h0);
    chk("rst_done",    {63'h0, done},    64'h0);
    chk("rst_nicEn",   {63'h0, nicEn},   64'h0);
    chk("rst_nicEnWR", {63'h0, nicEnWR}, 64'h0);
    chk("rst_addr",    {62'h0, addr},    64'h0);
    chk("rst_d_in",    d_in,             64'h0);
    chk("rst_tx_cnt",  {48'h0, tx_cnt},  64'h0);
    chk("rst_rx_cnt",  {48'h0, rx_cnt},  64'h0);
    chk("rst_last_rx", last_rx,          64'h0);
    chk("rst_rx_xor",  rx_xor,           64'h0);
    reset = 1'b1;
    @(negedge clk);
    chk("rel_nicEn", {63'h0, nicEn}, 64'h0);

    // three back-to-back writes, NIC never full
    num_pkts = 16'd3; exp_rx = 16'd0; gap = 8'd0; dest_hdr = 16'hBEEF;
    clear_log();
    pulse_start();
    chk("t35_busy", {63'h0, busy}, 64'h1);
    wait_done(200, "t35");
    chk("t35_busy_done", {63'h0, busy}, 64'h0);
    chk("t35_nwr",    64'(wr_time.size()), 64'd3);
    chk("t35_d0",     wd(0), 64'hBEEF_3C00_0000_0000);
    chk("t35_d1",     wd(1), 64'hBEEF_3C00_0000_0001);
    chk("t35_d2",     wd(2), 64'hBEEF_3C00_0000_0002);
    chk("t35_gap01",  64'(wt(1) - wt(0)), 64'd5);
    chk("t35_gap12",  64'(wt(2) - wt(1)), 64'd5);
    chk("t35_tx_cnt", {48'h0, tx_cnt}, 64'd3);
    @(negedge clk);
    chk("t35_idle_done", {63'h0, done}, 64'h0);
    chk("t35_held_tx",   {48'h0, tx_cnt}, 64'd3);

    // empty run: done five cycles after start
    num_pkts = 16'd0; exp_rx = 16'd0;
    clear_log();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (done !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t31_latency", 64'(n), 64'd5);
    chk("t31_nwr", 64'(wr_time.size()), 64'd0);
    chk("t31_tx_cnt_clr", {48'h0, tx_cnt}, 64'd0);
    @(negedge clk);

    // output buffer full for 10 cycles
    num_pkts = 16'd1; out_full = 1'b1;
    clear_log();
    pulse_start();
    repeat (10) @(negedge clk);
    chk("t36_nwr_full", 64'(wr_time.size()), 64'd0);
    chk("t36_busy", {63'h0, busy}, 64'h1);
    clr_time = cyc;
    out_full = 1'b0;
    wait_done(100, "t36");
    chk("t36_nwr", 64'(wr_time.size()), 64'd1);
    chk("t36_after_clear", {63'h0, wt(0) > clr_time}, 64'h1);
    @(negedge clk);

    // inter-write gap
    num_pkts = 16'd2; gap = 8'd20;
    clear_log();
    pulse_start();
    wait_done(300, "t37");
    chk("t37_nwr", 64'(wr_time.size()), 64'd2);
    chk("t37_spacing", {63'h0, (wt(1) - wt(0)) >= 21}, 64'h1);
    @(negedge clk);

    // receive two packets
    num_pkts = 16'd0; exp_rx = 16'd2; gap = 8'd0;
    in_q.push_back(64'hA5);
    in_q.push_back(64'h5A);
    clear_log();
    pulse_start();
    wait_done(200, "t38");
    chk("t38_last_rx", last_rx, 64'h5A);
    chk("t38_rx_cnt",  {48'h0, rx_cnt}, 64'd2);
    chk("t38_rx_xor",  rx_xor, XOR_EXP);
    chk("t38_nwr", 64'(wr_time.size()), 64'd0);
    @(negedge clk);

    // asynchronous reset while in WR
    num_pkts = 16'd3; exp_rx = 16'd0;
    pulse_start();
    n = 0;
    while (!(nicEn === 1'b1 && nicEnWR === 1'b1 && d_in[15:0] === 16'd1) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t39_reached_wr", {63'h0, n < 100}, 64'h1);
    #2 reset = 1'b0;
    #1;
    chk("t39_nicEn",  {63'h0, nicEn}, 64'h0);
    chk("t39_busy",   {63'h0, busy},  64'h0);
    chk("t39_tx_cnt", {48'h0, tx_cnt}, 64'h0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("t39_rel_nicEn", {63'h0, nicEn}, 64'h0);
    clear_log();
    pulse_start();
    wait_done(200, "t39");
    chk("t39_first_seq", {48'h0, wd(0)[15:0]}, 64'h0);
    chk("t39_nwr",    64'(wr_time.size()), 64'd3);
    chk("t39_tx_end", {48'h0, tx_cnt}, 64'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pe_traffic_gen.md
PE_TRAFFIC_GEN -- requirements
Module: pe_traffic_gen

Interface
REQ-001 SHALL have parameter PACKET_WIDTH, default 64, NIC data width.
REQ-002 SHALL have parameter SRC_ID, default 8'd0, source id stamped into packets.
REQ-003 SHALL have port clk, input, 1, the only clock; all state changes on rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset (0 = reset).
REQ-005 SHALL have port start, input, 1, begin run (sampled only in IDLE).
REQ-006 SHALL have port num_pkts, input, 16, packets to inject.
REQ-007 SHALL have port exp_rx, input, 16, packets to receive before done.
REQ-008 SHALL have port dest_hdr, input, 16, routing header placed in packet [63:48].
REQ-009 SHALL have port gap, input, 8, minimum idle cycles between NIC writes.
REQ-010 SHALL have port addr, output, 2, NIC register select.
REQ-011 SHALL have port d_in, output, PACKET_WIDTH, write data to NIC.
REQ-012 SHALL have port d_out, input, PACKET_WIDTH, NIC read data, registered by NIC, valid the cycle after a read request.
REQ-013 SHALL have ports nicEn and nicEnWR, output, 1 each, NIC access enable and write-not-read.
REQ-014 SHALL have ports busy and done, output, 1 each, run in progress and run complete.
REQ-015 SHALL have ports tx_cnt and rx_cnt, output, 16 each, packets written and read.
REQ-016 SHALL have ports last_rx and rx_xor, output, PACKET_WIDTH each, last received packet and running XOR.

Function
REQ-017 NIC map SHALL be: 2'b00 input buffer (read), 2'b01 input status (d_out[0]=1 packet waiting), 2'b10 output buffer (write), 2'b11 output status (d_out[0]=1 full).
REQ-018 FSM states SHALL be IDLE, POLL_OUT, CHK_OUT, WR, POLL_IN, CHK_IN, RD_IN, CAP_IN, DONE.
REQ-019 IDLE: start=1 clears tx_cnt, rx_cnt, gap counter, last_rx, rx_xor and moves to POLL_OUT; start while not IDLE ignored.
REQ-020 POLL_OUT: nicEn=1, nicEnWR=0, addr=11; next CHK_OUT.
REQ-021 CHK_OUT: if d_out[0]=0, tx_cnt<num_pkts and gap counter=0 go WR, else POLL_IN.
REQ-022 WR: nicEn=1, nicEnWR=1, addr=10, d_in={dest_hdr, SRC_ID, 8'h00, 16'h0000, tx_cnt}; tx_cnt+1; gap counter loads gap; next POLL_IN.
REQ-023 Gap counter SHALL decrement by 1 each cycle while non-zero, in every state except IDLE/WR.
REQ-024 POLL_IN: nicEn=1, nicEnWR=0, addr=01; next CHK_IN.
REQ-025 CHK_IN: d_out[0]=1 go RD_IN; else if tx_cnt==num_pkts and rx_cnt==exp_rx go DONE; else POLL_OUT.
REQ-026 RD_IN: nicEn=1, nicEnWR=0, addr=00; next CAP_IN.
REQ-027 CAP_IN: last_rx<=d_out, rx_cnt+1 (wraps at 16'hFFFF), rx_xor update per REQ-034; next POLL_OUT.
REQ-028 DONE: done=1, busy=0; returns to IDLE when start=0; counters and last_rx held.
REQ-029 busy SHALL be 1 in every state except IDLE and DONE.
REQ-030 In states not driving NIC, nicEn=0, nicEnWR=0, addr=00, d_in=0.
REQ-031 num_pkts=0 SHALL produce no writes; num_pkts=0 and exp_rx=0 reaches DONE after one poll loop (5 cycles after start).
REQ-032 Packets arriving after rx_cnt==exp_rx but before DONE SHALL still be read and counted.

Reset
REQ-033 reset=0 SHALL asynchronously force IDLE, all outputs and counters 0, including mid-run; no NIC access in the cycle reset releases.

Configuration
REQ-034 Macro PE_TRAFFIC_GEN_RXXOR_EN defined: CAP_IN sets rx_xor<=rx_xor^d_out; undefined: rx_xor constant 0 and no XOR register synthesised.

Verification
REQ-035 start, num_pkts=3, exp_rx=0, gap=0, NIC never full/empty -> three writes, d_in[15:0]=0,1,2, writes 5 cycles apart, DONE, tx_cnt=3.
REQ-036 Output status full for 10 cycles, num_pkts=1 -> no WR while full; single write after full clears.
REQ-037 num_pkts=2, gap=20 -> second write no earlier than 21 cycles after first.
REQ-038 Input status set with packets 64'hA5, 64'h5A, exp_rx=2, num_pkts=0 -> last_rx=64'h5A, rx_cnt=2, rx_xor=64'hFF (0 when macro undefined), done=1.
REQ-039 reset=0 asserted in WR state -> nicEn, busy, tx_cnt 0 immediately; start after release restarts from tx_cnt=0.
